// File: rtl/ssm_mul_pkg.sv
// Shared definitions for the SSM lane multiplier array: operand modes, FP16
// constants and the lane slicing helper.
package ssm_mul_pkg;

    typedef enum logic [1:0] {
        MODE_MUL   = 2'b00,
        MODE_BCAST = 2'b01,
        MODE_SQR   = 2'b10,
        MODE_RSV   = 2'b11
    } mode_e;

    localparam int FP16_W = 16;
    localparam logic [FP16_W-1:0] FP16_ZERO = 16'h0000;

    // Widest lane bus the helper accepts; narrower buses are zero-extended first.
    localparam int MAX_LANES = 64;
    localparam int BUS_W     = MAX_LANES * FP16_W;

    function automatic logic [FP16_W-1:0] lane_slice(input logic [BUS_W-1:0] bus,
                                                     input int lane);
        return bus[FP16_W*lane +: FP16_W];
    endfunction

endpackage

// File: rtl/fp16_mul_wrapper.sv
// Fixed-latency FP16 multiplier, round-to-nearest-even, subnormals flushed to zero.
// Products appear LAT-1 registers after the operands (LAT counts the input cycle).
module fp16_mul_wrapper #(
    parameter int LAT = 6
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        valid_in,
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic        valid_out,
    output logic [15:0] p
);

    function automatic logic [15:0] fp16_mul(input logic [15:0] x, input logic [15:0] y);
        logic              s, x_nan, y_nan, x_inf, y_inf, x_zero, y_zero, g, st;
        logic [21:0]       prod;
        logic signed [7:0] e;
        logic [10:0]       m;
        logic [15:0]       r;
        s      = x[15] ^ y[15];
        x_nan  = (x[14:10] == 5'h1F) && (x[9:0] != '0);
        y_nan  = (y[14:10] == 5'h1F) && (y[9:0] != '0);
        x_inf  = (x[14:10] == 5'h1F) && (x[9:0] == '0);
        y_inf  = (y[14:10] == 5'h1F) && (y[9:0] == '0);
        x_zero = (x[14:10] == 5'h00);
        y_zero = (y[14:10] == 5'h00);
        prod   = 22'({1'b1, x[9:0]}) * 22'({1'b1, y[9:0]});
        e      = $signed({3'b000, x[14:10]}) + $signed({3'b000, y[14:10]}) - 8'sd15;
        m      = '0;
        g      = 1'b0;
        st     = 1'b0;
        r      = '0;
        if (x_nan || y_nan || (x_inf && y_zero) || (y_inf && x_zero)) begin
            r = 16'h7E00;
        end else if (x_inf || y_inf) begin
            r = {s, 5'h1F, 10'h000};
        end else if (x_zero || y_zero) begin
            r = {s, 15'h0000};
        end else begin
            if (prod[21]) begin
                m  = {1'b0, prod[20:11]};
                g  = prod[10];
                st = |prod[9:0];
                e  = e + 8'sd1;
            end else begin
                m  = {1'b0, prod[19:10]};
                g  = prod[9];
                st = |prod[8:0];
            end
            if (g && (st || m[0])) m = m + 11'd1;
            // Rounding carried out of the mantissa: renormalise.
            if (m[10]) begin
                m = '0;
                e = e + 8'sd1;
            end
            if (e >= 8'sd31)     r = {s, 5'h1F, 10'h000};
            else if (e <= 8'sd0) r = {s, 15'h0000};
            else                 r = {s, e[4:0], m[9:0]};
        end
        return r;
    endfunction

    logic [15:0] prod_p0;

    assign prod_p0 = fp16_mul(a, b);

    if (LAT <= 1) begin : g_comb
        assign valid_out = valid_in;
        assign p         = prod_p0;
    end else begin : g_pipe
        logic [LAT-2:0] vld_p;
        logic [15:0]    prod_p [LAT-1];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                vld_p <= '0;
            end else begin
                vld_p[0] <= valid_in;
                for (int i = 1; i < LAT - 1; i++) vld_p[i] <= vld_p[i-1];
            end
        end

        always_ff @(posedge clk) begin
            prod_p[0] <= prod_p0;
            for (int i = 1; i < LAT - 1; i++) prod_p[i] <= prod_p[i-1];
        end

        assign valid_out = vld_p[LAT-2];
        assign p         = prod_p[LAT-2];
    end

endmodule

// File: rtl/lane_fifo.sv
// Show-ahead FIFO with occupancy count; when empty the output holds the last
// popped entry (zero after reset).
module lane_fifo #(
    parameter  int WIDTH = 8,
    parameter  int DEPTH = 8,
    localparam int CNT_W = $clog2(DEPTH + 1),
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
    input  logic             clk,
    input  logic             rstn,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic [CNT_W-1:0] count,
    output logic             full,
    output logic             empty
);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic [WIDTH-1:0] hold;
    logic             do_wr;
    logic             do_rd;

    function automatic logic [PTR_W-1:0] ptr_inc(input logic [PTR_W-1:0] ptr);
        return (ptr == PTR_W'(DEPTH - 1)) ? '0 : ptr + PTR_W'(1);
    endfunction

    assign full  = (count == CNT_W'(DEPTH));
    assign empty = (count == '0);
    assign do_wr = wr_en && !full;
    assign do_rd = rd_en && !empty;

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            hold   <= '0;
        end else begin
            if (do_wr) wr_ptr <= ptr_inc(wr_ptr);
            if (do_rd) begin
                rd_ptr <= ptr_inc(rd_ptr);
                hold   <= mem[rd_ptr];
            end
            case ({do_wr, do_rd})
                2'b10:   count <= count + CNT_W'(1);
                2'b01:   count <= count - CNT_W'(1);
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = empty ? hold : mem[rd_ptr];

endmodule

// File: rtl/ssm_lane_mul_q.sv
// H_TILE-lane FP16 multiplier array with operand modes, lane mask and tag,
// decoupled from downstream backpressure by a credit-guarded output FIFO.
module ssm_lane_mul_q
    import ssm_mul_pkg::*;
#(
    parameter int DW     = 16,
    parameter int H_TILE = 4,
    parameter int M_LAT  = 6,
    parameter int FIFO_D = 8,
    parameter int TAG_W  = 8
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 valid_i,
    output logic                 ready_o,
    input  logic [1:0]           mode_i,
    input  logic [H_TILE-1:0]    mask_i,
    input  logic [TAG_W-1:0]     tag_i,
    input  logic [H_TILE*DW-1:0] lhs_i,
    input  logic [H_TILE*DW-1:0] rhs_i,
    output logic                 valid_o,
    input  logic                 ready_i,
    output logic [H_TILE*DW-1:0] mul_o,
    output logic [TAG_W-1:0]     tag_o,
    output logic                 err_o
);

    if (DW != FP16_W) begin : g_dw_chk
        $error("ssm_lane_mul_q: DW must be 16");
    end
    if (H_TILE < 1 || H_TILE > MAX_LANES) begin : g_lane_chk
        $error("ssm_lane_mul_q: H_TILE out of range");
    end
    if (M_LAT < 1) begin : g_lat_chk
        $error("ssm_lane_mul_q: M_LAT must be at least 1");
    end
    if (FIFO_D < M_LAT + 2) begin : g_depth_chk
        $error("ssm_lane_mul_q: FIFO_D must be at least M_LAT+2");
    end

    localparam int CW   = $clog2(FIFO_D + 1);
    localparam int FW   = H_TILE * DW + TAG_W;

    logic [CW-1:0]                credits;
    logic                         accept;
    logic                         pop;
    logic [BUS_W-1:0]             lhs_ext;
    logic [BUS_W-1:0]             rhs_ext;
    logic [H_TILE-1:0][DW-1:0]    prod;
    logic [H_TILE-1:0]            wrap_vld;
    logic                         tail_vld;
    logic [H_TILE-1:0]            tail_mask;
    logic [TAG_W-1:0]             tail_tag;
    logic [FW-1:0]                wr_data;
    logic [FW-1:0]                rd_data;
    logic [CW-1:0]                fifo_count;
    logic                         fifo_full;
    logic                         fifo_empty;

    assign ready_o = (credits != '0);
    assign accept  = valid_i && ready_o;
    assign valid_o = !fifo_empty;
    assign pop     = valid_o && ready_i;

    // Credits count free slots over FIFO plus pipeline, so writes never hit a full FIFO.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            credits <= CW'(FIFO_D);
        end else if (accept && !pop) begin
            credits <= credits - CW'(1);
        end else if (pop && !accept) begin
            credits <= credits + CW'(1);
        end
    end

    assign lhs_ext = BUS_W'(lhs_i);
    assign rhs_ext = BUS_W'(rhs_i);

    // Stage 0: operand selection and per-lane multipliers
    for (genvar h = 0; h < H_TILE; h++) begin : g_lane
        logic [DW-1:0] op_a;
        logic [DW-1:0] op_b;

        always_comb begin
            op_a = lane_slice(lhs_ext, h);
            case (mode_e'(mode_i))
                MODE_BCAST: op_b = lane_slice(rhs_ext, 0);
                MODE_SQR:   op_b = op_a;
                default:    op_b = lane_slice(rhs_ext, h);
            endcase
        end

        fp16_mul_wrapper #(
            .LAT(M_LAT)
        ) u_mul (
            .clk      (clk),
            .rstn     (rstn),
            .valid_in (accept),
            .a        (op_a),
            .b        (op_b),
            .valid_out(wrap_vld[h]),
            .p        (prod[h])
        );
    end

    // Stages 1..M_LAT-1: sideband travels in lockstep with the multipliers
    if (M_LAT == 1) begin : g_sb_comb
        assign tail_vld  = accept;
        assign tail_mask = mask_i;
        assign tail_tag  = tag_i;
    end else begin : g_sb_pipe
        logic [M_LAT-2:0]  vld_p;
        logic [H_TILE-1:0] mask_p [M_LAT-1];
        logic [TAG_W-1:0]  tag_p  [M_LAT-1];

        always_ff @(posedge clk) begin
            if (!rstn) begin
                vld_p <= '0;
                for (int i = 0; i < M_LAT - 1; i++) begin
                    mask_p[i] <= '0;
                    tag_p[i]  <= '0;
                end
            end else begin
                vld_p[0]  <= accept;
                mask_p[0] <= mask_i;
                tag_p[0]  <= tag_i;
                for (int i = 1; i < M_LAT - 1; i++) begin
                    vld_p[i]  <= vld_p[i-1];
                    mask_p[i] <= mask_p[i-1];
                    tag_p[i]  <= tag_p[i-1];
                end
            end
        end

        assign tail_vld  = vld_p[M_LAT-2];
        assign tail_mask = mask_p[M_LAT-2];
        assign tail_tag  = tag_p[M_LAT-2];
    end

    // Tail: masked lanes are forced to +0 whatever the product, NaN included
    always_comb begin
        wr_data = '0;
        for (int h = 0; h < H_TILE; h++) begin
            wr_data[h*DW +: DW] = tail_mask[h] ? prod[h] : FP16_ZERO;
        end
        wr_data[H_TILE*DW +: TAG_W] = tail_tag;
    end

    lane_fifo #(
        .WIDTH(FW),
        .DEPTH(FIFO_D)
    ) u_fifo (
        .clk    (clk),
        .rstn   (rstn),
        .wr_en  (tail_vld),
        .wr_data(wr_data),
        .rd_en  (pop),
        .rd_data(rd_data),
        .count  (fifo_count),
        .full   (fifo_full),
        .empty  (fifo_empty)
    );

    assign mul_o = rd_data[H_TILE*DW-1:0];
    assign tag_o = rd_data[H_TILE*DW +: TAG_W];

    always_ff @(posedge clk) begin
        if (!rstn) begin
            err_o <= 1'b0;
        end else if (tail_vld && fifo_full) begin
            err_o <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rstn) begin
            assert (wrap_vld == {H_TILE{tail_vld}});
            assert (int'(fifo_count) + int'(credits) <= FIFO_D);
        end
    end

endmodule

// File: tb/tb_ssm_lane_mul_q.sv
// Scoreboard bench for ssm_lane_mul_q: directed vectors, FIFO fill/drain,
// randomised handshakes over the vector table, and mid-flight reset.
module tb_ssm_lane_mul_q;

    localparam int H      = 4;
    localparam int DW     = 16;
    localparam int M_LAT  = 6;
    localparam int FIFO_D = 8;
    localparam int TAG_W  = 8;
    localparam int BW     = H * DW;
    localparam int NV     = 6;

    logic             clk = 1'b0;
    logic             rstn = 1'b0;
    logic             valid_i = 1'b0;
    logic             ready_o;
    logic [1:0]       mode_i = '0;
    logic [H-1:0]     mask_i = '0;
    logic [TAG_W-1:0] tag_i = '0;
    logic [BW-1:0]    lhs_i = '0;
    logic [BW-1:0]    rhs_i = '0;
    logic             valid_o;
    logic             ready_i = 1'b0;
    logic [BW-1:0]    mul_o;
    logic [TAG_W-1:0] tag_o;
    logic             err_o;

    always #5 clk = ~clk;

    ssm_lane_mul_q #(
        .DW(DW), .H_TILE(H), .M_LAT(M_LAT), .FIFO_D(FIFO_D), .TAG_W(TAG_W)
    ) dut (
        .clk(clk), .rstn(rstn), .valid_i(valid_i), .ready_o(ready_o),
        .mode_i(mode_i), .mask_i(mask_i), .tag_i(tag_i), .lhs_i(lhs_i), .rhs_i(rhs_i),
        .valid_o(valid_o), .ready_i(ready_i), .mul_o(mul_o), .tag_o(tag_o), .err_o(err_o)
    );

    // Hand-computed vectors; lane 0 is the rightmost 16-bit field.
    logic [1:0]    v_mode [NV] = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b01};
    logic [H-1:0]  v_mask [NV] = '{4'b1111, 4'b1111, 4'b0101, 4'b1111, 4'b1010, 4'b1111};
    logic [BW-1:0] v_lhs  [NV] = '{64'h4000_4000_4000_4000, 64'h4400_BE00_4000_3C00,
                                   64'h3800_3800_3800_3800, 64'h4400_3800_C000_3C00,
                                   64'h0000_7C00_3C00_7E00, 64'h3800_C400_3C00_4200};
    logic [BW-1:0] v_rhs  [NV] = '{64'h4200_4200_4200_4200, 64'h7C00_7C00_7C00_4000,
                                   64'h7C00_7C00_7C00_7C00, 64'h3C00_4000_4000_4000,
                                   64'h3C00_0000_3C00_3C00, 64'h0000_0000_0000_BC00};
    logic [BW-1:0] v_exp  [NV] = '{64'h4600_4600_4600_4600, 64'h4800_C200_4400_4000,
                                   64'h0000_3400_0000_3400, 64'h4400_3C00_C400_4000,
                                   64'h0000_0000_3C00_0000, 64'hB800_4400_BC00_C200};

    typedef struct packed {
        logic [BW-1:0]    mul;
        logic [TAG_W-1:0] tag;
    } beat_t;

    beat_t sb[$];
    beat_t exp_beat;
    int    n_vec = 0;
    int    n_bad = 0;
    int    cred  = FIFO_D;
    bit    done  = 1'b0;

    task automatic check(input string name, input logic [BW-1:0] act, input logic [BW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, want %0h", name, act, exp);
        end
    endtask

    task automatic fail_now(input string name, input int act, input int exp);
        n_vec++;
        n_bad++;
        $display("FAIL %s: got %0d, want %0d", name, act, exp);
    endtask

    // Monitor: pops the scoreboard on every output handshake and tracks credits.
    always @(negedge clk) begin
        if (rstn) begin
            check("ready_o vs credit model", 64'(ready_o), 64'(cred != 0));
            check("err_o", 64'(err_o), 64'd0);
            if (valid_o && ready_i) begin
                if (sb.size() == 0) begin
                    fail_now("stale beat on output (tag)", int'(tag_o), -1);
                end else begin
                    exp_beat = sb.pop_front();
                    check("mul_o", mul_o, exp_beat.mul);
                    check("tag_o", 64'(tag_o), 64'(exp_beat.tag));
                end
            end
            cred = cred + ((valid_o && ready_i) ? 1 : 0) - ((valid_i && ready_o) ? 1 : 0);
            if (cred < 0 || cred > FIFO_D) fail_now("credit range", cred, FIFO_D);
        end else begin
            cred = FIFO_D;
        end
    end

    task automatic load(input int vi, input logic [TAG_W-1:0] tag);
        mode_i = v_mode[vi];
        mask_i = v_mask[vi];
        lhs_i  = v_lhs[vi];
        rhs_i  = v_rhs[vi];
        tag_i  = tag;
    endtask

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input int vi, input logic [TAG_W-1:0] tag, input int max_wait);
        load(vi, tag);
        valid_i = 1'b1;
        for (int w = 0; ; w++) begin
            @(negedge clk);
            if (ready_o) begin
                sb.push_back({v_exp[vi], tag});
                break;
            end
            if (w >= max_wait) begin
                fail_now("send timeout (tag)", int'(tag), -1);
                break;
            end
            @(posedge clk);
            #1;
        end
        @(posedge clk);
        #1;
        valid_i = 1'b0;
    endtask

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic drain(input string name);
        for (int w = 0; w < 100 && sb.size() != 0; w++) step(1);
        check(name, 64'(sb.size()), 64'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time %0t, want completion", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n_acc;

        step(3);
        rstn = 1'b1;
        @(negedge clk);
        check("reset valid_o", 64'(valid_o), 64'd0);
        check("reset ready_o", 64'(ready_o), 64'd1);
        check("reset mul_o", mul_o, 64'd0);
        check("reset tag_o", 64'(tag_o), 64'd0);
        check("reset err_o", 64'(err_o), 64'd0);

        // MUL 2.0*3.0 with latency and single-pulse check
        step(1);
        ready_i = 1'b1;
        send(0, 8'h5A, 10);
        for (int k = 1; k <= M_LAT + 3; k++) begin
            @(negedge clk);
            check($sformatf("latency valid_o cycle %0d", k), 64'(valid_o), 64'(k == M_LAT));
        end
        step(1);

        // All table vectors back to back
        for (int vi = 1; vi < NV; vi++) send(vi, 8'(8'h10 + vi), 10);
        drain("directed drain");

        // Fill with output stalled
        ready_i = 1'b0;
        n_acc = 0;
        valid_i = 1'b1;
        for (int i = 0; i < 20; i++) begin
            load(0, 8'(n_acc));
            @(negedge clk);
            if (ready_o) begin
                sb.push_back({v_exp[0], 8'(n_acc)});
                n_acc++;
            end
            step(1);
        end
        valid_i = 1'b0;
        check("fill accepted count", 64'(n_acc), 64'(FIFO_D));
        @(negedge clk);
        check("fill ready_o", 64'(ready_o), 64'd0);
        check("fill valid_o", 64'(valid_o), 64'd1);
        check("fill head tag", 64'(tag_o), 64'd0);
        check("fill err_o", 64'(err_o), 64'd0);
        step(1);
        ready_i = 1'b1;
        @(negedge clk);
        check("ready_o before first pop", 64'(ready_o), 64'd0);
        @(negedge clk);
        check("ready_o after first pop", 64'(ready_o), 64'd1);
        step(1);
        drain("fill drain");

        // Random handshakes over the vector table
        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 1000; i++) begin
                    step($urandom_range(0, 2));
                    send($urandom_range(0, NV - 1), 8'(i), 200);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    ready_i = ($urandom_range(0, 3) != 0);
                    step(1);
                end
                ready_i = 1'b1;
            end
        join
        drain("random drain");

        // Reset with two beats queued and three in flight
        ready_i = 1'b0;
        for (int i = 0; i < 5; i++) send(i, 8'(8'hA0 + i), 10);
        step(2);
        rstn = 1'b0;
        step(1);
        rstn = 1'b1;
        sb.delete();
        ready_i = 1'b1;
        @(negedge clk);
        check("post-reset valid_o", 64'(valid_o), 64'd0);
        check("post-reset ready_o", 64'(ready_o), 64'd1);
        step(15);
        send(2, 8'h77, 10);
        drain("post-reset drain");

        check("final err_o", 64'(err_o), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
